// File: rtl/sram_arb_pkg.sv
// Shared encodings and default widths for the SRAM port arbiter.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package sram_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   function automatic logic other_owner(input logic own);
      return (own == OWN_INST) ? OWN_DATA : OWN_INST;
   endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant picker for the two SRAM requesters.
// SRAM_ARB_ROUND_ROBIN_EN: alternate on contention, else data wins.
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_owner
);

   assign grant_valid = inst_req | data_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   always_comb begin
      grant_owner = OWN_INST;
      unique case (1'b1)
         inst_req & data_req: grant_owner = other_owner(last_grant);
         data_req:            grant_owner = OWN_DATA;
         default:             grant_owner = OWN_INST;
      endcase
   end
`else
   logic unused_last_grant;

   assign unused_last_grant = last_grant;
   assign grant_owner = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between IF and MEM, one transaction at a time.
// SRAM_ARB_ROUND_ROBIN_EN adds a last_grant register for fair arbitration.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W/8-1:0] inst_wstrb,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int STRB_W = DATA_W / 8;

   logic [1:0]        state;
   logic              owner;
   logic              wr_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [DATA_W-1:0] wdata_q;

   logic grant_valid;
   logic grant_owner;
   logic last_grant;
   logic take_grant;

   assign take_grant = (state == ST_IDLE) & grant_valid;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   always_ff @(posedge clk) begin
      if (reset)
         last_grant_q <= OWN_INST;
      else if (take_grant)
         last_grant_q <= grant_owner;
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = OWN_INST;
`endif

   sram_arb_pick u_pick (
      .inst_req    (inst_req),
      .data_req    (data_req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // Requester fields are captured once at grant; ADDR never looks at them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner   <= OWN_INST;
         wr_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  state <= ST_ADDR;
                  owner <= grant_owner;
                  if (grant_owner == OWN_DATA) begin
                     wr_q    <= data_wr;
                     size_q  <= data_size;
                     addr_q  <= data_addr;
                     wstrb_q <= data_wstrb;
                     wdata_q <= data_wdata;
                  end else begin
                     wr_q    <= inst_wr;
                     size_q  <= inst_size;
                     addr_q  <= inst_addr;
                     wstrb_q <= inst_wstrb;
                     wdata_q <= inst_wdata;
                  end
               end
            end
            ST_ADDR: begin
               if (mem_addr_ok)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_data_ok)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic in_addr;
   logic in_wait;
   logic addr_acc;
   logic data_acc;

   assign in_addr  = (state == ST_ADDR);
   assign in_wait  = (state == ST_WAIT);
   assign addr_acc = in_addr & mem_addr_ok;
   assign data_acc = in_wait & mem_data_ok;

   assign mem_req   = in_addr;
   assign mem_wr    = in_addr & wr_q;
   assign mem_size  = in_addr ? size_q  : '0;
   assign mem_addr  = in_addr ? addr_q  : '0;
   assign mem_wstrb = in_addr ? wstrb_q : '0;
   assign mem_wdata = in_addr ? wdata_q : '0;

   assign inst_addr_ok = addr_acc & (owner == OWN_INST);
   assign data_addr_ok = addr_acc & (owner == OWN_DATA);
   assign inst_data_ok = data_acc & (owner == OWN_INST);
   assign data_data_ok = data_acc & (owner == OWN_DATA);

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

endmodule
